// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared types and constants for the seven-segment scan driver.
//   seg_t        : 7-bit segment vector, bit0 = a .. bit6 = g (active-high, logical)
//   SEG_BLANK    : all segments off (logical)
//   HEX_GLYPHS   : a..g patterns for hex digits 0..F
//   slot_cycles(): clock cycles per digit slot for a given clock/refresh/digit count
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    localparam int PWM_LEVELS = 16;

    localparam seg_t HEX_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int slot_cycles(input int freq, input int refresh, input int num_digits);
        return freq / (refresh * num_digits);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if -- display content inputs and board pin outputs.
//   master : SoC/register side; drives mode, digits, hex, decpoints, blank, brightness
//   slave  : scan driver; drives seg, dp, an (physical polarity)
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    import seg7_pkg::*;

    logic                    mode;        // 0: raw segments, 1: hex nibbles
    logic [NUM_DIGITS*7-1:0] digits;      // raw segments, digit i at [7i+6:7i]
    logic [NUM_DIGITS*4-1:0] hex;         // nibble per digit, digit i at [4i+3:4i]
    logic [NUM_DIGITS-1:0]   decpoints;   // 1 = dp lit
    logic [NUM_DIGITS-1:0]   blank;       // 1 = digit dark
    logic [3:0]              brightness;  // duty level 0..15
    seg_t                    seg;         // segment pins a..g
    logic                    dp;          // decimal point pin
    logic [NUM_DIGITS-1:0]   an;          // digit enables

    modport master (
        output mode, digits, hex, decpoints, blank, brightness,
        input  seg, dp, an
    );

    modport slave (
        input  mode, digits, hex, decpoints, blank, brightness,
        output seg, dp, an
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode -- combinational hex nibble to a..g segment pattern.
//   nibble : 4-bit value 0..F
//   seg    : logical (active-high) segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- multiplexed N-digit seven-segment display driver.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : seg7_scan_driver_if.slave (content inputs, seg/dp/an pins)
// Each digit owns a slot of SLOT_CYCLES clocks; the first DEAD_CYCLES of a slot
// keep every anode off to avoid ghosting, and a 4-bit PWM phase gates the rest
// of the slot against the brightness level. All inputs are captured together
// at frame start so a frame never mixes old and new content.
// Optional: define SEG7_SCAN_LZS_EN for hex-mode leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int FREQ           = 100000000,
    parameter int REFRESH        = 1000,
    parameter int NUM_DIGITS     = 8,
    parameter int DEAD_CYCLES    = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);

    localparam int SLOT_CYCLES = slot_cycles(FREQ, REFRESH, NUM_DIGITS);
    localparam int PWM_DIV     = SLOT_CYCLES / PWM_LEVELS;
    localparam int SLOT_W      = $clog2(SLOT_CYCLES);
    localparam int DIV_W       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // XOR masks turning logical (1 = on) values into pin levels.
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam seg_t                  SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);

    if (SLOT_CYCLES < PWM_LEVELS) begin : g_err_slot
        $error("seg7_scan_driver: SLOT_CYCLES must be at least 16");
    end
    if (DEAD_CYCLES >= SLOT_CYCLES) begin : g_err_dead
        $error("seg7_scan_driver: DEAD_CYCLES must be below SLOT_CYCLES");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_err_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..16");
    end

    typedef struct packed {
        logic                    mode;
        logic [NUM_DIGITS*7-1:0] digits;
        logic [NUM_DIGITS*4-1:0] hex;
        logic [NUM_DIGITS-1:0]   decpoints;
        logic [NUM_DIGITS-1:0]   blank;
        logic [3:0]              brightness;
    } snap_t;

    logic [SLOT_W-1:0] slot_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        pwm_phase;
    logic [IDX_W-1:0]  idx;
    logic              first_cycle;
    snap_t             snap;

    logic slot_end;
    logic frame_end;

    assign slot_end  = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    // Scan timing: slot counter, PWM prescaler/phase and digit index.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            div_cnt     <= '0;
            pwm_phase   <= '0;
            idx         <= '0;
            first_cycle <= 1'b1;
        end else begin
            first_cycle <= 1'b0;
            if (slot_end) begin
                slot_cnt  <= '0;
                div_cnt   <= '0;
                pwm_phase <= '0;
                idx       <= frame_end ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
                if (div_cnt == DIV_W'(PWM_DIV - 1)) begin
                    div_cnt   <= '0;
                    pwm_phase <= pwm_phase + 1'b1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // Frame-coherent snapshot, loaded on the edge that returns idx to 0 and on
    // the first cycle out of reset.
    // NOTE: the snapshot is cleared in reset so a freshly reset display starts
    // dark (brightness 0) instead of showing stale content.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (first_cycle || frame_end) begin
            snap <= '{mode:       bus.mode,
                      digits:     bus.digits,
                      hex:        bus.hex,
                      decpoints:  bus.decpoints,
                      blank:      bus.blank,
                      brightness: bus.brightness};
        end
    end

    logic [3:0] cur_nibble;
    seg_t       hex_seg;
    seg_t       src_seg;
    logic       src_dp;
    logic       suppress;
    logic       lit;

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (hex_seg)
    );

`ifdef SEG7_SCAN_LZS_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 is never suppressed so an all-zero value still reads "0".
    assign suppress = snap.mode && (idx != '0)
                      && ((snap.hex >> (4 * int'(idx))) == '0);
`else
    assign suppress = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    always_comb begin
        cur_nibble = snap.hex[4 * int'(idx) +: 4];
        src_seg    = snap.mode ? hex_seg : snap.digits[7 * int'(idx) +: 7];
        src_dp     = snap.decpoints[idx];
        lit        = (int'(slot_cnt) >= DEAD_CYCLES)
                     && (pwm_phase < snap.brightness)
                     && !snap.blank[idx]
                     && !suppress;
    end

    // Registered pins; an is built from a single shifted bit, so at most one
    // digit is ever enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an  <= AN_INV;
            bus.seg <= SEG_INV;
            bus.dp  <= DP_INV;
        end else if (lit) begin
            bus.an  <= (NUM_DIGITS'(1) << idx) ^ AN_INV;
            bus.seg <= src_seg ^ SEG_INV;
            bus.dp  <= src_dp ^ DP_INV;
        end else begin
            bus.an  <= AN_INV;
            bus.seg <= SEG_BLANK ^ SEG_INV;
            bus.dp  <= DP_INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver -- directed self-checking bench for seg7_scan_driver.
// Configuration: FREQ=1600, REFRESH=25, NUM_DIGITS=4 (16-cycle slots, one PWM
// step per cycle), DEAD_CYCLES=2, active-low anodes and segments.
// Honours SEG7_SCAN_LZS_EN in its expected values.
module tb_seg7_scan_driver;

    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   k;       // clock edges since the last reset edge
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .FREQ           (1600),
        .REFRESH        (25),
        .NUM_DIGITS     (ND),
        .DEAD_CYCLES    (2),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected {an, seg, dp} pins for counter position n (n = 0 is slot 0,
    // cycle 0 of the first frame after reset), given the frame's inputs.
    function automatic logic [11:0] exp_out(input int n, input logic md,
                                            input logic [27:0] dg, input logic [15:0] hx,
                                            input logic [3:0] dpi, input logic [3:0] bl,
                                            input logic [3:0] br);
        int d = (n / 16) % ND;
        int c = n % 16;
        logic lit = (c >= 2) && (c < int'(br)) && !bl[d];
        logic [6:0] s = md ? glyph(hx[4*d +: 4]) : dg[7*d +: 7];
`ifdef SEG7_SCAN_LZS_EN
        if (md && d > 0 && (hx >> (4 * d)) == 16'h0) lit = 1'b0;
`endif
        if (lit) return {~(4'b0001 << d), ~s, ~dpi[d]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic set_inputs(input logic md, input logic [27:0] dg, input logic [15:0] hx,
                              input logic [3:0] dpi, input logic [3:0] bl, input logic [3:0] br);
        bus.mode       = md;
        bus.digits     = dg;
        bus.hex        = hx;
        bus.decpoints  = dpi;
        bus.blank      = bl;
        bus.brightness = br;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        set_inputs(1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, 4'd15);
        apply_reset();
        repeat (37) step();   // outputs now show digit 2, slot cycle 4 (lit)
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({bus.an, bus.seg, bus.dp} !== 12'hFFF) begin
                fails++;
                $display("FAIL reset_inactive cyc=%0d got an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1",
                         i, bus.an, bus.seg, bus.dp);
            end
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            e = exp_out(k - 1, 1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, 4'd15);
            tests++;
            if ({bus.an, bus.seg, bus.dp} !== e) begin
                fails++;
                $display("FAIL reset_restart n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_hex();
        logic [11:0] e;
        set_inputs(1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, 4'd15);
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            step();
            e = exp_out(k - 1, 1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, 4'd15);
            tests++;
            if ({bus.an, bus.seg, bus.dp} !== e) begin
                fails++;
                $display("FAIL hex_scan n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
            end
        end
        // Spot values taken straight from the hand table: digit 0 mid-slot, digit 3 mid-slot.
        step();   // n = 80 -> digit 1 slot, cycle 0
        repeat (32 + 4) step();   // n = 116 -> digit 3, cycle 4
        tests++;
        if (bus.an !== 4'b0111 || bus.seg !== ~7'h06) begin
            fails++;
            $display("FAIL hex_digit3 got an=%b seg=%h expected an=0111 seg=%h", bus.an, bus.seg, ~7'h06);
        end
        repeat (16) step();   // n = 132 -> digit 0, cycle 4
        tests++;
        if (bus.an !== 4'b1110 || bus.seg !== ~7'h71) begin
            fails++;
            $display("FAIL hex_digit0 got an=%b seg=%h expected an=1110 seg=%h", bus.an, bus.seg, ~7'h71);
        end
    endtask

    task automatic test_brightness();
        logic [11:0] e;
        for (int b = 0; b < 2; b++) begin
            logic [3:0] br = (b == 0) ? 4'd4 : 4'd0;
            set_inputs(1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, br);
            apply_reset();
            for (int i = 0; i < 64; i++) begin
                step();
                e = exp_out(k - 1, 1'b1, 28'h0, 16'h1A3F, 4'h0, 4'h0, br);
                tests++;
                if ({bus.an, bus.seg, bus.dp} !== e) begin
                    fails++;
                    $display("FAIL brightness_%0d n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                             br, k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
    endtask

    task automatic test_tearing();
        logic [11:0] e;
        logic [27:0] dg_a = {7'h08, 7'h04, 7'h02, 7'h01};
        logic [27:0] dg_b = {7'h40, 7'h30, 7'h22, 7'h11};
        set_inputs(1'b0, dg_a, 16'h0, 4'b0101, 4'h0, 4'd15);
        apply_reset();
        for (int i = 0; i < 140; i++) begin
            if (i == 21) begin
                // Mid-frame change of pattern, dp and brightness.
                bus.digits     = dg_b;
                bus.decpoints  = 4'b1010;
                bus.brightness = 4'd5;
            end
            step();
            if (k - 1 < 64) e = exp_out(k - 1, 1'b0, dg_a, 16'h0, 4'b0101, 4'h0, 4'd15);
            else            e = exp_out(k - 1, 1'b0, dg_b, 16'h0, 4'b1010, 4'h0, 4'd5);
            tests++;
            if ({bus.an, bus.seg, bus.dp} !== e) begin
                fails++;
                $display("FAIL tearing n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_blank();
        logic [11:0] e;
        set_inputs(1'b1, 28'h0, 16'h1A3F, 4'hF, 4'b0100, 4'd15);
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            step();
            e = exp_out(k - 1, 1'b1, 28'h0, 16'h1A3F, 4'hF, 4'b0100, 4'd15);
            tests++;
            if ({bus.an, bus.seg, bus.dp} !== e) begin
                fails++;
                $display("FAIL blank n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                         k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [11:0] e;
        for (int v = 0; v < 2; v++) begin
            logic [15:0] hx = (v == 0) ? 16'h0050 : 16'h0000;
            set_inputs(1'b1, 28'h0, hx, 4'h0, 4'h0, 4'd15);
            apply_reset();
            for (int i = 0; i < 64; i++) begin
                step();
                e = exp_out(k - 1, 1'b1, 28'h0, hx, 4'h0, 4'h0, 4'd15);
                tests++;
                if ({bus.an, bus.seg, bus.dp} !== e) begin
                    fails++;
                    $display("FAIL lzs_%h n=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
                             hx, k - 1, bus.an, bus.seg, bus.dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
        // Raw mode with zero-looking hex must never be suppressed.
        set_inputs(1'b0, {7'h3F, 7'h3F, 7'h06, 7'h5B}, 16'h0000, 4'h0, 4'h0, 4'd15);
        apply_reset();
        repeat (16 * 3 + 5) step();   // n = 52 -> digit 3, cycle 4
        tests++;
        if (bus.an !== 4'b0111 || bus.seg !== ~7'h3F) begin
            fails++;
            $display("FAIL lzs_raw got an=%b seg=%h expected an=0111 seg=%h", bus.an, bus.seg, ~7'h3F);
        end
    endtask

    initial begin
        set_inputs(1'b0, 28'h0, 16'h0, 4'h0, 4'h0, 4'd0);
        k = 0;
        test_reset();
        test_hex();
        test_brightness();
        test_tearing();
        test_blank();
        test_leading_zeros();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
